icache: RTL and testbench

Direct-mapped instruction cache serving the fetch queue's line requests. Accepts a level request with a 32-bit line address, returns one 128-bit line (four instructions, word 0 in bits 31:0) with a single-cycle `dout_valid` pulse. Misses trigger a 4-beat 32-bit burst refill from main memory. Sits between the fetch queue and the memory/bus interface.

---
 rtl/icache_pkg.sv | 16 +
 rtl/icache_refill_buf.sv | 48 ++++
 rtl/icache.sv | 160 ++++++++++++++++
 tb/tb_icache.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared widths and the controller state encoding for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned LINE_W      = 128;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BEATS       = 4;
    localparam int unsigned BEAT_W      = 2;
    localparam int unsigned LINE_ADDR_W = 28;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        REFILL
    } state_e;

endpackage

// File: rtl/icache_refill_buf.sv
// Refill assembly buffer: counts burst beats and builds the 128-bit line, the last beat bypassing the register.
module icache_refill_buf
    import icache_pkg::*;
(
    input  logic              clock,
    input  logic              nreset,
    input  logic              clr,
    input  logic              en,
    input  logic              beat_valid,
    input  logic [WORD_W-1:0] beat_data,
    output logic              last_beat_c,
    output logic [LINE_W-1:0] line_c
);

    logic [BEAT_W-1:0] cnt_q, cnt_d;
    logic [WORD_W-1:0] words_q [BEATS-1];
    logic [WORD_W-1:0] words_d [BEATS-1];

    // Only words 0..2 are held; word 3 is taken straight from the bus on the final beat.
    always_comb begin
        cnt_d   = cnt_q;
        words_d = words_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && beat_valid) begin
            cnt_d = cnt_q + BEAT_W'(1);
            if (cnt_q != BEAT_W'(BEATS - 1)) begin
                words_d[cnt_q] = beat_data;
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            cnt_q <= '0;
            for (int i = 0; i < BEATS - 1; i++) begin
                words_q[i] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            words_q <= words_d;
        end
    end

    assign last_beat_c = en && beat_valid && (cnt_q == BEAT_W'(BEATS - 1));
    assign line_c      = {beat_data, words_q[2], words_q[1], words_q[0]};

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: line lookup for the fetch queue with 4-beat burst refill on miss.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              rd_en,
    input  logic [31:0]       addr,
    input  logic              inv,
    output logic [LINE_W-1:0] dout,
    output logic              dout_valid,
    output logic              mem_rd_en,
    output logic [31:0]       mem_addr,
    input  logic [WORD_W-1:0] mem_data,
    input  logic              mem_data_valid
);

    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = LINE_ADDR_W - INDEX_BITS;

    state_e                 state_q, state_d;
    logic [LINE_ADDR_W-1:0] req_line_q, req_line_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic                   kill_q, kill_d;
    logic [LINE_W-1:0]      dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;
    logic                   mem_rd_en_q, mem_rd_en_d;
    logic [31:0]            mem_addr_q, mem_addr_d;

    logic [LINE_W-1:0]      data_mem_q [LINES];
    logic [TAG_W-1:0]       tag_mem_q  [LINES];

    logic [INDEX_BITS-1:0]  idx_c;
    logic [TAG_W-1:0]       req_tag_c;
    logic                   same_line_c;
    logic                   hit_c;
    logic                   kill_now_c;
    logic                   fill_we_c;
    logic                   last_beat_c;
    logic [LINE_W-1:0]      line_c;
    logic                   addr_unused_c;

    assign idx_c         = req_line_q[INDEX_BITS-1:0];
    assign req_tag_c     = req_line_q[LINE_ADDR_W-1:INDEX_BITS];
    assign same_line_c   = (addr[31:4] == req_line_q);
    assign hit_c         = valid_q[idx_c] && (tag_mem_q[idx_c] == req_tag_c) && !inv;
    assign kill_now_c    = kill_q || inv;
    assign addr_unused_c = ^addr[3:0];

    icache_refill_buf u_refill_buf (
        .clock       (clock),
        .nreset      (nreset),
        .clr         (state_q != REFILL),
        .en          (state_q == REFILL),
        .beat_valid  (mem_data_valid),
        .beat_data   (mem_data),
        .last_beat_c (last_beat_c),
        .line_c      (line_c)
    );

    // Controller next-state and registered outputs.
    always_comb begin
        state_d      = state_q;
        req_line_d   = req_line_q;
        valid_d      = valid_q;
        kill_d       = kill_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        mem_rd_en_d  = mem_rd_en_q;
        mem_addr_d   = mem_addr_q;
        fill_we_c    = 1'b0;

        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (rd_en) begin
                    req_line_d = addr[31:4];
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                if (!rd_en || !same_line_c) begin
                    state_d = IDLE;
                end else if (hit_c) begin
                    dout_d       = data_mem_q[idx_c];
                    dout_valid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = {req_line_q, 4'h0};
                    state_d     = REFILL;
                end
            end
            REFILL: begin
                if (inv) begin
                    kill_d = 1'b1;
                end
                // The burst always runs to completion; only validation and the response are suppressible.
                if (last_beat_c) begin
                    fill_we_c   = 1'b1;
                    mem_rd_en_d = 1'b0;
                    kill_d      = 1'b0;
                    state_d     = IDLE;
                    if (!kill_now_c) begin
                        valid_d[idx_c] = 1'b1;
                    end
                    if (rd_en && same_line_c && !kill_now_c) begin
                        dout_d       = line_c;
                        dout_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (inv) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q      <= IDLE;
            req_line_q   <= '0;
            valid_q      <= '0;
            kill_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            req_line_q   <= req_line_d;
            valid_q      <= valid_d;
            kill_q       <= kill_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    // Data and tag arrays carry no reset; the valid vector guards them.
    always_ff @(posedge clock) begin
        if (fill_we_c) begin
            data_mem_q[idx_c] <= line_c;
            tag_mem_q[idx_c]  <= req_tag_c;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign mem_rd_en  = mem_rd_en_q;
    assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: scenario tasks plus randomized fetches against a line-level cache model.
module tb_icache;

    logic         clock = 1'b0;
    logic         nreset;
    logic         rd_en;
    logic [31:0]  addr;
    logic         inv;
    logic [127:0] dout;
    logic         dout_valid;
    logic         mem_rd_en;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_data;
    logic         mem_data_valid;

    int checks   = 0;
    int failures = 0;

    bit          m_valid [64];
    logic [21:0] m_tag   [64];

    int          burst_count  = 0;
    int          beats_sent   = 0;
    bit          burst_active = 0;
    logic [31:0] burst_base   = '0;

    int           pulse_count  = 0;
    logic [127:0] last_pulse   = '0;
    bit           prev_dv      = 0;
    bit           double_pulse = 0;

    always #5 clock = ~clock;

    icache #(.INDEX_BITS(6)) dut (
        .clock          (clock),
        .nreset         (nreset),
        .rd_en          (rd_en),
        .addr           (addr),
        .inv            (inv),
        .dout           (dout),
        .dout_valid     (dout_valid),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_data_valid (mem_data_valid)
    );

    // Backing instruction memory contents, one 128-bit line per line address.
    function automatic logic [127:0] line_data(input logic [27:0] line);
        logic [127:0] r;
        if (line == 28'h0000100) begin
            r = {32'h44, 32'h33, 32'h22, 32'h11};
        end else begin
            for (int w = 0; w < 4; w++) begin
                r[w*32 +: 32] = ({4'h0, line} * 32'h9E3779B1) ^ (32'(w + 1) * 32'h85EBCA6B);
            end
        end
        return r;
    endfunction

    // Memory side: serves bursts with random gaps, abandons a burst if mem_rd_en drops.
    initial begin
        logic [127:0] ld;
        mem_data_valid = 1'b0;
        mem_data       = '0;
        forever begin
            @(negedge clock);
            mem_data_valid = 1'b0;
            if (mem_rd_en === 1'b1) begin
                if (!burst_active) begin
                    burst_active = 1;
                    beats_sent   = 0;
                    burst_base   = mem_addr;
                    burst_count++;
                end
                if (beats_sent < 4 && $urandom_range(0, 3) != 0) begin
                    ld             = line_data(burst_base[31:4]);
                    mem_data       = ld[beats_sent*32 +: 32];
                    mem_data_valid = 1'b1;
                    beats_sent++;
                end
            end else begin
                burst_active = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (dout_valid === 1'b1) begin
                pulse_count++;
                last_pulse = dout;
                if (prev_dv) double_pulse = 1;
            end
            prev_dv = (dout_valid === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_valid[i] = 0;
    endtask

    task automatic inv_pulse();
        tick();
        inv = 1'b1;
        tick();
        inv = 1'b0;
        model_clear();
    endtask

    task automatic wait_beats(input int b0, input int n, input string name);
        int budget = 0;
        while (!(burst_count == b0 + 1 && beats_sent >= n) && budget < 200) begin
            tick();
            budget++;
        end
        checks++;
        if (budget >= 200) begin
            failures++;
            $display("FAIL %s_beat_wait: beats=%0d bursts=%0d required beats=%0d", name, beats_sent, burst_count - b0, n);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (dout !== 128'h0 || dout_valid !== 1'b0 || mem_rd_en !== 1'b0 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL %s: dout=%h dv=%b mem_rd_en=%b mem_addr=%h required all zero", name, dout, dout_valid, mem_rd_en, mem_addr);
        end
    endtask

    // One complete fetch transaction; hit/miss and data predicted from the model and backing memory.
    task automatic fetch(input logic [31:0] a);
        logic [27:0]  line    = a[31:4];
        int           idx     = int'(line[5:0]);
        logic [21:0]  tg      = line[27:6];
        bit           exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        int           b0      = burst_count;
        int           p0      = pulse_count;
        int           cyc     = 0;
        bit           got     = 0;
        logic         mre2    = 1'b0;
        logic [127:0] exp_d   = line_data(line);
        tick();
        rd_en = 1'b1;
        addr  = a;
        while (!got && cyc < 200) begin
            tick();
            cyc++;
            if (cyc == 2) mre2 = mem_rd_en;
            if (dout_valid === 1'b1) got = 1;
        end
        rd_en = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL fetch_timeout %h: no dout_valid within %0d cycles", a, cyc);
        end else begin
            checks++;
            if (dout !== exp_d) begin
                failures++;
                $display("FAIL fetch_data %h: got %h required %h", a, dout, exp_d);
            end
        end
        checks++;
        if (burst_count - b0 != (exp_hit ? 0 : 1)) begin
            failures++;
            $display("FAIL fetch_bursts %h: got %0d required %0d", a, burst_count - b0, exp_hit ? 0 : 1);
        end
        checks++;
        if (exp_hit) begin
            if (cyc != 2) begin
                failures++;
                $display("FAIL hit_latency %h: got %0d required 2", a, cyc);
            end
        end else begin
            if (mre2 !== 1'b1 || burst_base !== {line, 4'h0}) begin
                failures++;
                $display("FAIL miss_request %h: mem_rd_en@2=%b mem_addr=%h required 1 and %h", a, mre2, burst_base, {line, 4'h0});
            end
        end
        tick();
        checks++;
        if (dout_valid !== 1'b0 || pulse_count - p0 != 1) begin
            failures++;
            $display("FAIL pulse_shape %h: dv=%b pulses=%0d required 0 and 1", a, dout_valid, pulse_count - p0);
        end
        m_valid[idx] = 1;
        m_tag[idx]   = tg;
    endtask

    task automatic test_reset();
        rd_en  = 1'b0;
        inv    = 1'b0;
        addr   = '0;
        nreset = 1'b1;
        #2 nreset = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset_values");
        nreset = 1'b1;
        repeat (2) tick();
        check_idle_outputs("after_reset_release");
        model_clear();
    endtask

    task automatic test_cold_miss();
        fetch(32'h0000_1000);
        checks++;
        if (last_pulse !== 128'h00000044_00000033_00000022_00000011) begin
            failures++;
            $display("FAIL cold_miss_line: got %h required 00000044_00000033_00000022_00000011", last_pulse);
        end
    endtask

    task automatic test_hit();
        fetch(32'h0000_100C);
        fetch(32'h0000_1004);
    endtask

    task automatic test_conflict();
        fetch(32'h0000_1400);
        fetch(32'h0000_1000);
    endtask

    task automatic test_abort();
        int b0 = burst_count;
        int p0 = pulse_count;
        tick();
        rd_en = 1'b1;
        addr  = 32'h0000_7770;
        tick();
        rd_en = 1'b0;
        repeat (6) tick();
        checks++;
        if (burst_count != b0 || pulse_count != p0) begin
            failures++;
            $display("FAIL lookup_abort: bursts=%0d pulses=%0d required 0 and 0", burst_count - b0, pulse_count - p0);
        end
    endtask

    task automatic test_branch();
        int b0;
        int p0;
        int budget = 0;
        inv_pulse();
        b0 = burst_count;
        p0 = pulse_count;
        tick();
        rd_en = 1'b1;
        addr  = 32'h0000_1000;
        wait_beats(b0, 2, "branch");
        addr = 32'h0000_2000;
        while (pulse_count == p0 && budget < 300) begin
            tick();
            budget++;
        end
        rd_en = 1'b0;
        tick();
        checks++;
        if (pulse_count - p0 != 1 || last_pulse !== line_data(28'h0000200)) begin
            failures++;
            $display("FAIL branch_response: pulses=%0d data=%h required 1 and %h", pulse_count - p0, last_pulse, line_data(28'h0000200));
        end
        checks++;
        if (burst_count - b0 != 2 || burst_base !== 32'h0000_2000) begin
            failures++;
            $display("FAIL branch_bursts: bursts=%0d last_base=%h required 2 and 00002000", burst_count - b0, burst_base);
        end
        m_valid[0] = 1;
        m_tag[0]   = 22'h8;
        fetch(32'h0000_2008);
        fetch(32'h0000_1000);
    endtask

    task automatic test_inv_refill();
        int b0;
        int p0;
        int budget = 0;
        fetch(32'h0000_1010);
        b0 = burst_count;
        p0 = pulse_count;
        tick();
        rd_en = 1'b1;
        addr  = 32'h0000_3000;
        wait_beats(b0, 2, "inv");
        inv = 1'b1;
        tick();
        inv = 1'b0;
        model_clear();
        while (mem_rd_en === 1'b1 && budget < 200) begin
            tick();
            budget++;
        end
        rd_en = 1'b0;
        checks++;
        if (dout_valid !== 1'b0 || beats_sent != 4) begin
            failures++;
            $display("FAIL inv_burst_end: dv=%b beats=%0d required 0 and 4", dout_valid, beats_sent);
        end
        repeat (4) tick();
        checks++;
        if (pulse_count != p0) begin
            failures++;
            $display("FAIL inv_no_pulse: pulses=%0d required 0", pulse_count - p0);
        end
        fetch(32'h0000_3000);
        fetch(32'h0000_1010);
    endtask

    task automatic test_reset_mid();
        int b0 = burst_count;
        tick();
        rd_en = 1'b1;
        addr  = 32'h0000_5000;
        wait_beats(b0, 2, "reset_mid");
        nreset = 1'b0;
        rd_en  = 1'b0;
        #1;
        check_idle_outputs("reset_async");
        tick();
        check_idle_outputs("reset_mid_next");
        nreset = 1'b1;
        repeat (2) tick();
        model_clear();
        fetch(32'h0000_5000);
        fetch(32'h0000_5004);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) inv_pulse();
            a = 32'h0008_0000 | (32'($urandom_range(0, 2)) << 10) |
                (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15));
            fetch(a);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_abort();
        test_branch();
        test_inv_refill();
        test_reset_mid();
        test_random();
        checks++;
        if (double_pulse) begin
            failures++;
            $display("FAIL dout_valid_consecutive: got 1 required 0");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
